// File: rtl/merc_mem_pkg.sv
// Shared definitions for the MERC-16 memory responder: FSM states,
// the machine word width and the access error classification.
package merc_mem_pkg;

  localparam int MERC_WORD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Why an access was refused; kept for a future status register.
  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_RANGE      = 2'd2
  } err_cause_t;

  // Classify a byte address against a RAM of 2**addr_bits words.
  // Any address bit above the word index makes the access out of range,
  // so large addresses never alias onto low words.
  function automatic err_cause_t check_access(input logic [MERC_WORD-1:0] addr,
                                              input int addr_bits);
    logic [MERC_WORD-1:0] upper;
    upper = addr >> (addr_bits + 1);
    if (addr[0])
      return ERR_MISALIGNED;
    else if (upper != '0)
      return ERR_RANGE;
    else
      return ERR_NONE;
  endfunction

endpackage

// File: rtl/merc_word_ram.sv
// Single-port word RAM with synchronous write and registered read.
// Contents are deliberately not reset.
module merc_word_ram
  import merc_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [MERC_WORD-1:0] wdata,
  output logic [MERC_WORD-1:0] rdata
);

  logic [MERC_WORD-1:0] mem [0:(1<<ADDR_BITS)-1];

  // Write on an enabled write cycle, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      else
        rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/merc_mem_responder.sv
// Memory-side responder for the MERC-16 memory interface. Accepts one
// word request at a time, waits WAIT_CYCLES cycles, then performs the
// access on the edge that enters RESP and holds the response until acked.
module merc_mem_responder
  import merc_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [MERC_WORD-1:0] req_addr,
  input  logic [MERC_WORD-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ack,
  output logic [MERC_WORD-1:0] resp_rdata,
  output logic                 resp_error
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  state_t               state;
  logic [3:0]           wait_cnt;
  logic                 cap_write;
  logic [MERC_WORD-1:0] cap_addr;
  logic [MERC_WORD-1:0] cap_wdata;
  logic                 rdata_sel;

  logic                 accept;
  logic                 commit;
  logic                 acc_write;
  logic [MERC_WORD-1:0] acc_addr;
  logic [MERC_WORD-1:0] acc_wdata;
  err_cause_t           acc_err;
  logic                 ram_en;
  logic [MERC_WORD-1:0] ram_rdata;

  assign accept = (state == IDLE) && req_valid;

  // With no wait states the access commits on the accepting edge, so the
  // RAM must see the live request rather than the capture registers.
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    commit    = (state == WAIT) && (wait_cnt == 4'd0);
    if (NO_WAIT) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      commit    = accept;
    end
  end

  assign acc_err = check_access(acc_addr, ADDR_BITS);

  // Never touch the RAM while reset is held or when the access is refused.
  assign ram_en = commit && rst_n && (acc_err == ERR_NONE);

  merc_word_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (acc_write),
    .addr (acc_addr[ADDR_BITS:1]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  // The RAM read register holds its word through RESP; gate it to zero
  // whenever no successful read response is being presented.
  assign resp_rdata = rdata_sel ? ram_rdata : '0;

  // Request/wait/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      rdata_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (NO_WAIT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= (acc_err != ERR_NONE);
              rdata_sel  <= !acc_write && (acc_err == ERR_NONE);
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (commit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= (acc_err != ERR_NONE);
            rdata_sel  <= !acc_write && (acc_err == ERR_NONE);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ack) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            rdata_sel  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          rdata_sel  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merc_mem_responder.sv
// Bench for merc_mem_responder: one instance with two wait states (d=0)
// and one with zero wait states (d=1), checked against a word-array model.
module tb_merc_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ack, a_resp_error;
  logic [15:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ack, b_resp_error;
  logic [15:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] mdl   [2][256];
  bit          known [2][256];

  always #5 clk = ~clk;

  merc_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ack(a_resp_ack),
    .resp_rdata(a_resp_rdata), .resp_error(a_resp_error)
  );

  merc_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ack(b_resp_ack),
    .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
  );

  // Drive the request/ack inputs of one instance.
  task automatic drive(input int d, input logic v, input logic w,
                       input logic [15:0] a, input logic [15:0] wd, input logic ack);
    if (d == 0) begin
      a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = wd; a_resp_ack = ack;
    end else begin
      b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = wd; b_resp_ack = ack;
    end
  endtask

  // Sample the outputs of one instance.
  task automatic peek(input int d, output logic rdy, output logic vld,
                      output logic err, output logic [15:0] rd);
    if (d == 0) begin
      rdy = a_req_ready; vld = a_resp_valid; err = a_resp_error; rd = a_resp_rdata;
    end else begin
      rdy = b_req_ready; vld = b_resp_valid; err = b_resp_error; rd = b_resp_rdata;
    end
  endtask

  // Reference model: what a word memory of 256 entries should answer.
  task automatic model_txn(input int d, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, output logic [15:0] exp_rd,
                           output logic exp_err, output bit exp_known);
    int a;
    a = int'(addr);
    exp_err   = ((a % 2) != 0) || ((a / 2) >= 256);
    exp_rd    = 16'h0000;
    exp_known = 1'b1;
    if (!exp_err) begin
      if (wr) begin
        mdl[d][a / 2]   = wd;
        known[d][a / 2] = 1'b1;
      end else begin
        exp_rd    = mdl[d][a / 2];
        exp_known = known[d][a / 2];
      end
    end
  endtask

  // Run one transaction from a negedge to the negedge after the ack edge.
  // While holding the response, a different write request stays asserted.
  task automatic run_txn(input int d, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input int hold,
                         input logic [15:0] pend_addr, input logic [15:0] pend_wd,
                         output int wait_n, output int lat, output logic [15:0] rd,
                         output logic er, output bit hold_ok, output bit idle_ok,
                         output bit timeout);
    logic rdy, vld, e2;
    logic [15:0] r2;
    timeout = 1'b0; hold_ok = 1'b1; idle_ok = 1'b0; lat = 0; wait_n = 0;
    rd = 16'h0; er = 1'b0;
    drive(d, 1'b1, wr, addr, wd, 1'b0);
    peek(d, rdy, vld, e2, r2);
    while (!rdy && wait_n < 50) begin
      @(posedge clk); @(negedge clk);
      peek(d, rdy, vld, e2, r2);
      wait_n++;
    end
    if (!rdy) begin
      timeout = 1'b1;
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      return;
    end
    @(posedge clk);
    lat = 1;
    #1;
    if (hold > 0) drive(d, 1'b1, 1'b1, pend_addr, pend_wd, 1'b0);
    else          drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    peek(d, rdy, vld, er, rd);
    while (!vld && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      peek(d, rdy, vld, er, rd);
    end
    if (!vld) begin
      timeout = 1'b1;
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      peek(d, rdy, vld, e2, r2);
      if (r2 !== rd || e2 !== er || vld !== 1'b1 || rdy !== 1'b0) hold_ok = 1'b0;
    end
    if (d == 0) a_resp_ack = 1'b1; else b_resp_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    peek(d, rdy, vld, e2, r2);
    idle_ok = (rdy === 1'b1) && (vld === 1'b0) && (e2 === 1'b0) && (r2 === 16'h0);
  endtask

  // Reset values, both while reset is held and right after release.
  task automatic test_reset();
    logic rdy, vld, err;
    logic [15:0] rd;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      drive(d, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      peek(d, rdy, vld, err, rd);
      vectors++;
      if ({rdy, vld, err, rd} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
        miscompares++;
        $display("[TB] FAIL reset_held d=%0d: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0000",
                 d, rdy, vld, err, rd);
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      peek(d, rdy, vld, err, rd);
      vectors++;
      if ({rdy, vld, err, rd} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
        miscompares++;
        $display("[TB] FAIL reset_release d=%0d: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0000",
                 d, rdy, vld, err, rd);
      end
    end
  endtask

  // Directed transaction with full checking of latency, data, error and return to idle.
  task automatic directed(input string name, input int d, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wd);
    int wn, lat, exp_lat;
    logic [15:0] rd, exp_rd;
    logic er, exp_err;
    bit hok, iok, to, kn;
    model_txn(d, wr, addr, wd, exp_rd, exp_err, kn);
    exp_lat = (d == 0) ? 3 : 1;
    run_txn(d, wr, addr, wd, 0, 16'h0, 16'h0, wn, lat, rd, er, hok, iok, to);
    vectors++;
    if (to || lat != exp_lat) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d (timeout=%0d) want %0d", name, lat, to, exp_lat);
    end
    vectors++;
    if (er !== exp_err || (kn && rd !== exp_rd)) begin
      miscompares++;
      $display("[TB] FAIL %s response: got err=%b rd=%h want err=%b rd=%h",
               name, er, rd, exp_err, exp_rd);
    end
    vectors++;
    if (!iok) begin
      miscompares++;
      $display("[TB] FAIL %s idle_after_ack: got 0 want 1", name);
    end
  endtask

  task automatic test_write_read();
    directed("write_beef", 0, 1'b1, 16'h0014, 16'hBEEF);
    directed("read_beef", 0, 1'b0, 16'h0014, 16'h0000);
  endtask

  task automatic test_misaligned();
    directed("misaligned_write", 0, 1'b1, 16'h0015, 16'h1234);
    directed("read_after_misaligned", 0, 1'b0, 16'h0014, 16'h0000);
  endtask

  task automatic test_out_of_range();
    directed("oor_read_0200", 0, 1'b0, 16'h0200, 16'h0000);
    directed("oor_write_8000", 0, 1'b1, 16'h8000, 16'h7777);
    directed("last_word_write", 0, 1'b1, 16'h01FE, 16'h5A5A);
    directed("last_word_read", 0, 1'b0, 16'h01FE, 16'h0000);
    directed("word0_read_after_oor", 0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Long-held response with a competing request that must not be captured.
  task automatic test_hold();
    int wn, lat;
    logic [15:0] rd;
    logic er;
    bit hok, iok, to;
    directed("hold_setup", 0, 1'b1, 16'h0030, 16'h1111);
    run_txn(0, 1'b0, 16'h0014, 16'h0, 5, 16'h0030, 16'h5555, wn, lat, rd, er, hok, iok, to);
    vectors++;
    if (to || !hok || rd !== mdl[0][10] || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_stable: got ok=%0d rd=%h err=%b want ok=1 rd=%h err=0",
               hok && !to, rd, er, mdl[0][10]);
    end
    vectors++;
    if (!iok) begin
      miscompares++;
      $display("[TB] FAIL hold_idle_after_ack: got 0 want 1");
    end
    run_txn(0, 1'b0, 16'h0030, 16'h0, 0, 16'h0, 16'h0, wn, lat, rd, er, hok, iok, to);
    vectors++;
    if (to || wn != 0 || lat != 3) begin
      miscompares++;
      $display("[TB] FAIL next_accept: got wait=%0d lat=%0d want wait=0 lat=3", wn, lat);
    end
    vectors++;
    if (rd !== 16'h1111 || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignored_request: got rd=%h err=%b want rd=1111 err=0", rd, er);
    end
  endtask

  // Reset during WAIT abandons the pending write.
  task automatic test_reset_mid_wait();
    logic rdy, vld, err;
    logic [15:0] rd;
    drive(0, 1'b1, 1'b1, 16'h0014, 16'hAAAA, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    peek(0, rdy, vld, err, rd);
    vectors++;
    if (rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_wait_busy: got rdy=%b want 0", rdy);
    end
    rst_n = 1'b0;
    #2;
    peek(0, rdy, vld, err, rd);
    vectors++;
    if ({rdy, vld, err, rd} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL mid_wait_reset: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0000",
               rdy, vld, err, rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    directed("read_after_abandon", 0, 1'b0, 16'h0014, 16'h0000);
  endtask

  task automatic test_zero_wait();
    directed("zw_write", 1, 1'b1, 16'h0014, 16'hC0DE);
    directed("zw_read", 1, 1'b0, 16'h0014, 16'h0000);
    directed("zw_misaligned", 1, 1'b1, 16'h0003, 16'hFFFF);
    directed("zw_oor", 1, 1'b0, 16'hF000, 16'h0000);
  endtask

  // Random mix on both instances; unknown reads become writes.
  task automatic test_random();
    logic [15:0] addr, wd;
    logic wr;
    int d, a;
    for (int n = 0; n < 40; n++) begin
      d    = int'($urandom_range(0, 1));
      wr   = 1'($urandom);
      wd   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) addr = 16'($urandom);
      else addr = 16'($urandom_range(0, 15) * 2 + 16'h0040);
      a = int'(addr);
      if (!wr && (a % 2) == 0 && (a / 2) < 256 && !known[d][a / 2]) wr = 1'b1;
      directed("random", d, wr, addr, wd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin
        mdl[d][i]   = 16'h0;
        known[d][i] = 1'b0;
      end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_hold();
    test_reset_mid_wait();
    test_zero_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/merc_mem_responder.md
Name: merc_mem_responder

Overview:
- Memory-side responder for the MERC-16 processor memory interface. Serves word read/write requests issued by the PC/memory subsystem side.
- Backed by an internal word RAM with a configurable number of wait states.
- Flags misaligned and out-of-range accesses instead of completing them.
- Lets the core's multicycle FSM be exercised against a memory with real handshake latency rather than a zero-wait block RAM.

Parameters:
- ADDR_BITS, 8, log2 of RAM depth in 16-bit words (256 words).
- WAIT_CYCLES, 2, cycles spent in WAIT before the response is presented; range 0..15.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- ReqValid  input  1  request present.
- ReqReady  output  1  responder can accept a request this cycle.
- ReqWrite  input  1  1 = write, 0 = read.
- ReqAddr  input  16  byte address; word index = ReqAddr[ADDR_BITS:1].
- ReqWData  input  16  write data.
- RespValid  output  1  response present.
- RespAck  input  1  requester consumes the response.
- RespRData  output  16  read data; 0 for writes and errors.
- RespError  output  1  access was misaligned or out of range.

Behaviour:
- Reset (Reset=0, asynchronous) forces the following:
  - State goes to IDLE.
  - ReqReady=1, RespValid=0, RespRData=0, RespError=0.
  - Wait counter is cleared.
  - RAM contents are not cleared.
- Reset mid-transaction abandons the transaction. A write that had not yet reached its commit edge is not performed.
- State IDLE:
  - ReqReady=1.
  - On ReqValid=1 at a rising edge, capture ReqWrite, ReqAddr and ReqWData into request registers.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- State WAIT:
  - ReqReady=0.
  - The counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - When the counter is 0, go to RESP.
- Transition into RESP (on the commit edge):
  - The access is in error if the captured addr[0]=1 (misaligned), or if ADDR_BITS<15 and addr[15:ADDR_BITS+1]!=0 (out of range).
  - Error: RespError=1 and RespRData=0; the RAM is not modified.
  - Read without error: RespRData = RAM[word index].
  - Write without error: RAM[word index] is written on that same edge; RespRData=0.
- State RESP:
  - RespValid=1 and ReqReady=0.
  - Outputs hold stable until RespAck=1 at a rising edge.
  - After the ack, return to IDLE with RespValid=0, RespError=0 and RespRData=0.
- Request-to-response latency is WAIT_CYCLES+1 edges from the accepting edge.
- Only one transaction is outstanding at a time.
- ReqValid held high during WAIT or RESP is ignored. A new request is accepted no earlier than the first edge after returning to IDLE, so there is no back-to-back acceptance on the ack edge.
- RespAck outside RESP is ignored.
- Read-after-write to the same word returns the newly written data.
- Word index arithmetic is unsigned and does not wrap. Addresses beyond the RAM depth are errors, never aliases.

Decomposition:
- Shared package merc_mem_pkg holds:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Word width constant MERC_WORD=16.
  - Error-cause encoding, reserved for a later status register.
- One natural sub-module: merc_word_ram. It is a single-port synchronous-write, registered-read RAM parameterised by ADDR_BITS. The responder FSM drives its enable, write and address.

Test Plan:
- Reset check: drive Reset=0 with any inputs, then release. Required: ReqReady=1, RespValid=0, RespRData=0 and RespError=0, both during reset and on the first cycle after release.
- Write then read, WAIT_CYCLES=2:
  - Write 0xBEEF to address 0x0014; RespValid rises exactly 3 edges after acceptance, with RespError=0 and RespRData=0.
  - Then read 0x0014. Required: RespRData=0xBEEF.
- Misaligned write: write 0x1234 to address 0x0015. Required: RespError=1 and RespRData=0. A following read of 0x0014 must still return 0xBEEF.
- Out of range, ADDR_BITS=8: read address 0x0200. Required: RespError=1 and RespRData=0.
- Response hold and ignored request: hold RespAck=0 for 5 cycles while ReqValid stays 1. Required: RespValid and RespRData stay stable and no new request is captured. Assert RespAck for one cycle; the next request is then accepted on the following IDLE edge.
- Reset mid-WAIT and zero-wait latency:
  - Issue a write of 0xAAAA to 0x0014, then assert Reset during WAIT. Required: a subsequent read of 0x0014 returns 0xBEEF.
  - Repeat the write-then-read with WAIT_CYCLES=0. Required: RespValid 1 edge after acceptance.
